// File: rtl/conv_pkg.sv
// Shared FSM state type and elaboration-time sizing helpers for the
// convolution layer sequencer.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, FIN} seq_state_e;

    // Bits needed to index n entries, never narrower than one bit.
    function automatic int logb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int array_size(input int image_size, input int kernel_size, input int stride);
        return (image_size - kernel_size) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Row-start pixel address and weight index for one MAC step, computed at
// 32-bit width from the loop indices and captured into output registers.
module conv_seq_addr_gen #(
    parameter int KERNEL_SIZE       = 3,
    parameter int IMAGE_SIZE        = 8,
    parameter int STRIDE            = 1,
    parameter int IN_CHANNEL        = 2,
    parameter int IMG_BASE          = 1,
    parameter int IDX_W             = 2,
    parameter int ROW_W             = 3,
    parameter int CH_W              = 1,
    parameter int K_W               = 2,
    parameter int EXT_ADDR_WIDTH    = 8,
    parameter int WEIGHT_ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [IDX_W-1:0]             idx,
    input  logic [ROW_W-1:0]             row,
    input  logic [CH_W-1:0]              ch,
    input  logic [K_W-1:0]               kr,
    input  logic [K_W-1:0]               kc,
    output logic [EXT_ADDR_WIDTH-1:0]    ext_rom_addr,
    output logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr
);

    // Outputs hold between loads, so they keep the last MAC step's value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_rom_addr <= '0;
            weight_addr  <= '0;
        end else if (load) begin
            ext_rom_addr <= EXT_ADDR_WIDTH'(32'(IMG_BASE)
                          + 32'(ch) * 32'(IMAGE_SIZE * IMAGE_SIZE)
                          + (32'(row) * 32'(STRIDE) + 32'(kr)) * 32'(IMAGE_SIZE)
                          + 32'(kc));
            weight_addr  <= WEIGHT_ADDR_WIDTH'(((32'(idx) * 32'(IN_CHANNEL) + 32'(ch))
                          * 32'(KERNEL_SIZE) + 32'(kr)) * 32'(KERNEL_SIZE) + 32'(kc));
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Convolution layer control sequencer: walks idx/row/ch/kr/kc, drains the MAC
// pipeline and hands each feature row downstream with valid/ready.
// Optional CONV_SEQ_PERF_CNT_EN adds stall_cycles / layer_cycles counters.
module conv_layer_sequencer import conv_pkg::*; #(
    parameter int KERNEL_SIZE      = 3,
    parameter int IMAGE_SIZE       = 8,
    parameter int STRIDE           = 1,
    parameter int IN_CHANNEL       = 2,
    parameter int TOTAL_WEIGHT     = 4,
    parameter int MAC_LATENCY      = 4,
    parameter int IMG_BASE         = 1,
    parameter int WEIGHT_ROM_DEPTH = 128,
    localparam int ARRAY_SIZE        = array_size(IMAGE_SIZE, KERNEL_SIZE, STRIDE),
    localparam int EXT_ADDR_WIDTH    = logb2(IMG_BASE + IN_CHANNEL * IMAGE_SIZE * IMAGE_SIZE),
    localparam int WEIGHT_ADDR_WIDTH = logb2(WEIGHT_ROM_DEPTH),
    localparam int IDX_W             = logb2(TOTAL_WEIGHT),
    localparam int ROW_W             = logb2(ARRAY_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         ready,
    output logic [EXT_ADDR_WIDTH-1:0]    ext_rom_addr,
    output logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr,
    output logic                         mac_en,
    output logic                         array_clear,
    output logic                         valid,
    output logic [IDX_W-1:0]             feature_idx,
    output logic [ROW_W-1:0]             feature_row,
    output logic                         busy,
    output logic                         image_calc_fin
`ifdef CONV_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  layer_cycles
`endif
);

    localparam int CH_W = logb2(IN_CHANNEL);
    localparam int K_W  = logb2(KERNEL_SIZE);
    localparam int DR_W = logb2(MAC_LATENCY + 1);

    if (TOTAL_WEIGHT * IN_CHANNEL * KERNEL_SIZE * KERNEL_SIZE > WEIGHT_ROM_DEPTH) begin : g_bad_wrom
        $error("conv_layer_sequencer: weight range exceeds WEIGHT_ROM_DEPTH");
    end
    if ((IMAGE_SIZE - KERNEL_SIZE) % STRIDE != 0) begin : g_bad_stride
        $error("conv_layer_sequencer: (IMAGE_SIZE-KERNEL_SIZE) not a multiple of STRIDE");
    end

    seq_state_e        state, state_nxt;
    logic [K_W-1:0]    kc, kr, kc_nxt, kr_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DR_W-1:0]   drain_cnt, drain_nxt;
    logic              kc_last, kr_last, ch_last, mac_last, row_last, idx_last, drain_done;
    logic              accept, addr_load;

    assign kc_last    = (kc == K_W'(KERNEL_SIZE - 1));
    assign kr_last    = (kr == K_W'(KERNEL_SIZE - 1));
    assign ch_last    = (ch == CH_W'(IN_CHANNEL - 1));
    assign mac_last   = kc_last && kr_last && ch_last;
    assign row_last   = (row == ROW_W'(ARRAY_SIZE - 1));
    assign idx_last   = (idx == IDX_W'(TOTAL_WEIGHT - 1));
    assign drain_done = (drain_cnt == DR_W'(MAC_LATENCY > 0 ? MAC_LATENCY - 1 : 0));
    assign accept     = (state == OUT) && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable)     state_nxt = MAC;
            MAC:     if (mac_last)   state_nxt = (MAC_LATENCY == 0) ? OUT : DRAIN;
            DRAIN:   if (drain_done) state_nxt = OUT;
            OUT:     if (ready)      state_nxt = (row_last && idx_last) ? FIN : MAC;
            FIN:                     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mac_en         = 1'b0;
        array_clear    = 1'b0;
        valid          = 1'b0;
        image_calc_fin = 1'b0;
        busy           = 1'b1;
        unique case (state)
            IDLE:    begin busy = 1'b0; array_clear = enable; end
            MAC:     mac_en = 1'b1;
            OUT:     begin valid = 1'b1; array_clear = ready; end
            FIN:     image_calc_fin = 1'b1;
            default: ;
        endcase
    end

    // Loop nest kc -> kr -> ch wraps to zero by itself on the last MAC step.
    always_comb begin
        kc_nxt    = kc;
        kr_nxt    = kr;
        ch_nxt    = ch;
        row_nxt   = row;
        idx_nxt   = idx;
        drain_nxt = (state == DRAIN) ? drain_cnt + DR_W'(1) : '0;
        if (state == MAC) begin
            kc_nxt = kc_last ? '0 : kc + K_W'(1);
            if (kc_last) begin
                kr_nxt = kr_last ? '0 : kr + K_W'(1);
                if (kr_last) ch_nxt = ch_last ? '0 : ch + CH_W'(1);
            end
        end
        if (accept) begin
            row_nxt = row_last ? '0 : row + ROW_W'(1);
            if (row_last) idx_nxt = idx_last ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc <= '0; kr <= '0; ch <= '0; row <= '0; idx <= '0; drain_cnt <= '0;
        end else begin
            kc <= kc_nxt; kr <= kr_nxt; ch <= ch_nxt;
            row <= row_nxt; idx <= idx_nxt; drain_cnt <= drain_nxt;
        end
    end

    assign feature_idx = idx;
    assign feature_row = row;

    // Address registers load the upcoming step's indices so they line up with mac_en.
    assign addr_load = (state_nxt == MAC);

    conv_seq_addr_gen #(
        .KERNEL_SIZE(KERNEL_SIZE), .IMAGE_SIZE(IMAGE_SIZE), .STRIDE(STRIDE),
        .IN_CHANNEL(IN_CHANNEL), .IMG_BASE(IMG_BASE),
        .IDX_W(IDX_W), .ROW_W(ROW_W), .CH_W(CH_W), .K_W(K_W),
        .EXT_ADDR_WIDTH(EXT_ADDR_WIDTH), .WEIGHT_ADDR_WIDTH(WEIGHT_ADDR_WIDTH)
    ) u_addr_gen (
        .clk(clk), .rst_n(rst_n), .load(addr_load),
        .idx(idx_nxt), .row(row_nxt), .ch(ch_nxt), .kr(kr_nxt), .kc(kc_nxt),
        .ext_rom_addr(ext_rom_addr), .weight_addr(weight_addr)
    );

`ifdef CONV_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            layer_cycles <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                stall_cycles <= '0;
                layer_cycles <= '0;
            end
        end else begin
            layer_cycles <= layer_cycles + 32'd1;
            if (state == OUT && !ready) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
